// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one common data bus (CDB) among FU_COUNT functional units.
// Each FU owns a one-entry holding buffer. A round-robin search over the valid
// buffers, starting at rr_ptr, picks one buffer per cycle. The winner's fields
// are registered onto the CDB.
//
// Ports:
//   clk          single clock; all state updates on its rising edge
//   rst          synchronous active-low reset
//   fu_valid     per-FU result-present flags
//   fu_vals      per-FU result values
//   fu_tags      per-FU destination physical-register tags
//   fu_robids    per-FU ROB ids
//   fu_ready     per-FU accept strobe; a result is taken when fu_valid & fu_ready
//   cdbval       broadcast value (registered)
//   cdbid        broadcast tag (registered)
//   cdbrobid     broadcast ROB id (registered)
//   cdbtransmit  the CDB fields are valid this cycle
//   grant_fu     index of the FU whose result is on the CDB
module cdb_arbiter #(
  parameter int unsigned FU_COUNT = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TAG_W    = 4,
  localparam int unsigned PTR_W   = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FU_COUNT-1:0]                fu_valid,
  input  logic [FU_COUNT-1:0][DATA_W-1:0]    fu_vals,
  input  logic [FU_COUNT-1:0][TAG_W-1:0]     fu_tags,
  input  logic [FU_COUNT-1:0][TAG_W-1:0]     fu_robids,
  output logic [FU_COUNT-1:0]                fu_ready,
  output logic [DATA_W-1:0]                  cdbval,
  output logic [TAG_W-1:0]                   cdbid,
  output logic [TAG_W-1:0]                   cdbrobid,
  output logic                               cdbtransmit,
  output logic [PTR_W-1:0]                   grant_fu
);

  // Holding buffers
  logic [FU_COUNT-1:0]             hold_valid_q;
  logic [FU_COUNT-1:0][DATA_W-1:0] hold_val_q;
  logic [FU_COUNT-1:0][TAG_W-1:0]  hold_tag_q;
  logic [FU_COUNT-1:0][TAG_W-1:0]  hold_rob_q;

  logic [PTR_W-1:0] rr_ptr_q;

  // Arbitration results for the current cycle
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [FU_COUNT-1:0] grant_vec;
  logic [FU_COUNT-1:0] accept;

  int unsigned         pos;
  logic [PTR_W-1:0]    cand;

  // Round-robin search: the first valid buffer at or after rr_ptr, wrapping to 0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    pos       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < FU_COUNT; k++) begin
      pos  = (int'(rr_ptr_q) + k) % FU_COUNT;
      cand = PTR_W'(pos);
      if (!grant_any && hold_valid_q[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (grant_any) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  // A granted buffer drains this edge, so it can take a new result at the same time.
  // This lets a single FU sustain one result per cycle.
  assign fu_ready = rst ? (~hold_valid_q | grant_vec) : '0;
  assign accept   = fu_valid & fu_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_valid_q <= '0;
      hold_val_q   <= '0;
      hold_tag_q   <= '0;
      hold_rob_q   <= '0;
      rr_ptr_q     <= '0;
      cdbval       <= '0;
      cdbid        <= '0;
      cdbrobid     <= '0;
      cdbtransmit  <= 1'b0;
      grant_fu     <= '0;
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        if (accept[i]) begin
          hold_valid_q[i] <= 1'b1;
          hold_val_q[i]   <= fu_vals[i];
          hold_tag_q[i]   <= fu_tags[i];
          hold_rob_q[i]   <= fu_robids[i];
        end else if (grant_vec[i]) begin
          hold_valid_q[i] <= 1'b0;
        end
      end

      if (grant_any) begin
        cdbval      <= hold_val_q[grant_idx];
        cdbid       <= hold_tag_q[grant_idx];
        cdbrobid    <= hold_rob_q[grant_idx];
        grant_fu    <= grant_idx;
        cdbtransmit <= 1'b1;
        rr_ptr_q    <= (grant_idx == PTR_W'(FU_COUNT - 1)) ? '0 : grant_idx + PTR_W'(1);
      end else begin
        // The CDB fields keep their previous values; only the valid flag drops.
        cdbtransmit <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter FU_COUNT, default 8, giving the number of functional units sharing the CDB.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the result value width.
REQ-003 The block SHALL have parameter TAG_W, default 4, giving the physical-register-tag and ROB-id width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port fu_valid, input, FU_COUNT bits: FU i presents a completed result.
REQ-007 The block SHALL have port fu_vals, input, FU_COUNT x DATA_W: result values.
REQ-008 The block SHALL have port fu_tags, input, FU_COUNT x TAG_W: destination physical-register tags.
REQ-009 The block SHALL have port fu_robids, input, FU_COUNT x TAG_W: ROB ids of the results.
REQ-010 The block SHALL have port fu_ready, output, FU_COUNT bits: FU i's result is accepted on an edge where fu_valid[i] && fu_ready[i].
REQ-011 The block SHALL have port cdbval, output, DATA_W: broadcast value.
REQ-012 The block SHALL have port cdbid, output, TAG_W: broadcast tag.
REQ-013 The block SHALL have port cdbrobid, output, TAG_W: broadcast ROB id.
REQ-014 The block SHALL have port cdbtransmit, output, 1 bit: CDB fields are valid this cycle.
REQ-015 The block SHALL have port grant_fu, output, $clog2(FU_COUNT) bits: index of the FU whose result is on the CDB.

Function
REQ-016 Each FU SHALL own one holding buffer holding valid, val, tag and robid.
REQ-017 fu_ready[i] SHALL be 1 when buf_valid[i]==0 or buffer i is granted this cycle, and SHALL NOT depend on fu_valid.
REQ-018 An accept SHALL load buffer i and set buf_valid[i]; a grant with no simultaneous accept SHALL clear buf_valid[i].
REQ-019 A grant and an accept on the same FU in the same cycle SHALL leave buf_valid[i]=1 holding the new result.
REQ-020 Each cycle, at most one grant SHALL be issued, chosen combinationally among the valid buffers by round-robin search starting at rr_ptr, ascending with wrap from FU_COUNT-1 to 0.
REQ-021 On a grant to FU w, rr_ptr SHALL become (w+1) mod FU_COUNT; with no grant, rr_ptr SHALL hold.
REQ-022 The granted buffer's fields SHALL be registered into cdbval, cdbid and cdbrobid, with grant_fu=w and cdbtransmit=1, on the same edge.
REQ-023 With no grant, cdbtransmit SHALL be 0 next cycle and cdbval, cdbid, cdbrobid and grant_fu SHALL hold their previous values.
REQ-024 Latency SHALL be exactly 2 edges from accept to visibility: accept at edge N, grant in cycle N..N+1, CDB valid after edge N+1, provided the FU wins arbitration immediately.
REQ-025 A single active FU SHALL sustain one broadcast per cycle.
REQ-026 Each cdbtransmit pulse SHALL correspond to exactly one accepted result, with no duplication and no loss.
REQ-027 Any continuously valid buffer SHALL be granted within FU_COUNT cycles.
REQ-028 Results from one FU SHALL be broadcast in acceptance order.

Reset
REQ-029 While rst==0 at a posedge, all buf_valid SHALL clear, rr_ptr=0, cdbtransmit=0, cdbval=0, cdbid=0, cdbrobid=0 and grant_fu=0.
REQ-030 fu_ready SHALL be 0 while rst==0, and no accept SHALL occur.
REQ-031 Reset asserted mid-operation SHALL discard all buffered results, with no broadcast in the cycle after that reset edge.

Verification
REQ-032 Single result: after reset, FU3 presents val=0xA5, tag=7, robid=2 for one cycle -> two edges later cdbtransmit=1, cdbval=0xA5, cdbid=7, cdbrobid=2, grant_fu=3 for exactly one cycle.
REQ-033 Contention: FU0, FU1 and FU5 are all valid in the same cycle with rr_ptr=0 -> broadcasts occur in order 0, 1, 5 on consecutive cycles, and rr_ptr ends at 6.
REQ-034 Wrap and fairness: rr_ptr=6 and FU7 and FU2 are both valid -> FU7 wins first, then FU2; FU2 is held continuously valid while all other FUs request -> FU2 is granted within 8 cycles.
REQ-035 Back-to-back single FU: FU4 is valid for 5 consecutive cycles with vals 1..5 -> fu_ready[4] stays 1, cdbtransmit=1 for 5 consecutive cycles carrying 1..5 in order.
REQ-036 Backpressure: FU1's buffer is full and loses arbitration to FU0 -> fu_ready[1]=0 for that cycle, and the FU1 input is held and then accepted without loss.
REQ-037 Reset mid-operation: rst=0 for one edge while 3 buffers are valid -> no cdbtransmit follows, all outputs are 0, and fu_ready returns to all-ones after rst=1.
